// File: rtl/dma_sched.sv
// Two-requester round-robin DMA descriptor scheduler: it issues one dma_enable per beat and steps the addresses.
// Optional WAIT-state timeout: define DMA_SCHED_TIMEOUT_EN to enable it (TIMEOUT_CYCLES sets the limit).
module dma_sched #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_h,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_rw,
  input  logic [7:0] req0_sdram_addr,
  input  logic [5:0] req0_mem_addr,
  input  logic [3:0] req0_len,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_rw,
  input  logic [7:0] req1_sdram_addr,
  input  logic [5:0] req1_mem_addr,
  input  logic [3:0] req1_len,
  input  logic       beat_done,
  output logic       dma_enable,
  output logic       rw,
  output logic [7:0] latch_sdram_addr_src,
  output logic [7:0] latch_sdram_addr_dst,
  output logic [5:0] latch_mem1_addr,
  output logic [5:0] latch_mem2_addr,
  output logic       busy,
  output logic       grant_id,
  output logic       xfer_done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dma_sched: TIMEOUT_CYCLES must be 1..255");
  end

  state_e     state_q;
  logic       rr_q;       // last requester served; reset to 1 so req0 wins first
  logic       rw_q, grant_q, dma_en_q, busy_q, done_q;
  logic [7:0] src_q, dst_q;
  logic [5:0] mem_q;
  logic [4:0] rem_q;

  logic       gnt0, gnt1, acc, sel;
  logic       d_rw;
  logic [7:0] d_sd;
  logic [5:0] d_mem;
  logic [3:0] d_len;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = rr_q;
        gnt1 = !rr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign acc   = gnt0 | gnt1;
  assign sel   = gnt1;
  assign d_rw  = sel ? req1_rw         : req0_rw;
  assign d_sd  = sel ? req1_sdram_addr : req0_sdram_addr;
  assign d_mem = sel ? req1_mem_addr   : req0_mem_addr;
  assign d_len = sel ? req1_len        : req0_len;

  // State is already IDLE under reset; the gate keeps ready low while rst_n is held.
  assign req0_ready = gnt0 & rst_n;
  assign req1_ready = gnt1 & rst_n;

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= 1'b1;
      rw_q     <= 1'b0;
      grant_q  <= 1'b0;
      dma_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      mem_q    <= '0;
      rem_q    <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      dma_en_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: if (acc) begin
          state_q  <= ISSUE;
          dma_en_q <= 1'b1;
          busy_q   <= 1'b1;
          grant_q  <= sel;
          rw_q     <= d_rw;
          src_q    <= d_rw ? 8'd0 : d_sd;
          dst_q    <= d_rw ? d_sd : 8'd0;
          mem_q    <= d_mem;
          rem_q    <= {d_len == 4'd0, d_len};   // len 0 encodes 16 beats
`ifdef DMA_SCHED_TIMEOUT_EN
          err_q    <= 1'b0;
`endif
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef DMA_SCHED_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        WAIT: begin
          if (beat_done) begin
            if (rem_q == 5'd1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ISSUE;
              dma_en_q <= 1'b1;
              rem_q    <= rem_q - 5'd1;
              mem_q    <= mem_q + 6'd1;
              if (rw_q) dst_q <= dst_q + 8'd1;
              else      src_q <= src_q + 8'd1;
            end
          end
`ifdef DMA_SCHED_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rr_q    <= grant_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dma_enable           = dma_en_q;
  assign rw                   = rw_q;
  assign latch_sdram_addr_src = src_q;
  assign latch_sdram_addr_dst = dst_q;
  assign latch_mem1_addr      = mem_q;
  assign latch_mem2_addr      = mem_q;
  assign busy                 = busy_q;
  assign grant_id             = grant_q;
  assign xfer_done            = done_q;

endmodule

// File: tb/tb_dma_sched.sv
// Bench for dma_sched: a descriptor-level model checked every cycle, plus directed scenarios with literal expectations.
module tb_dma_sched;
`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic       clk_h = 1'b0, rst_n = 1'b0;
  logic       req0_valid = 0, req0_rw = 0, req1_valid = 0, req1_rw = 0, beat_done;
  logic [7:0] req0_sdram_addr = 0, req1_sdram_addr = 0;
  logic [5:0] req0_mem_addr = 0, req1_mem_addr = 0;
  logic [3:0] req0_len = 0, req1_len = 0;
  logic       req0_ready, req1_ready, dma_enable, rw, busy, grant_id, xfer_done, err;
  logic [7:0] latch_sdram_addr_src, latch_sdram_addr_dst;
  logic [5:0] latch_mem1_addr, latch_mem2_addr;

  always #5 clk_h = ~clk_h;

  dma_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_h(clk_h), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
    .req0_sdram_addr(req0_sdram_addr), .req0_mem_addr(req0_mem_addr), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
    .req1_sdram_addr(req1_sdram_addr), .req1_mem_addr(req1_mem_addr), .req1_len(req1_len),
    .beat_done(beat_done), .dma_enable(dma_enable), .rw(rw),
    .latch_sdram_addr_src(latch_sdram_addr_src), .latch_sdram_addr_dst(latch_sdram_addr_dst),
    .latch_mem1_addr(latch_mem1_addr), .latch_mem2_addr(latch_mem2_addr),
    .busy(busy), .grant_id(grant_id), .xfer_done(xfer_done), .err(err)
  );

  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {28'd0, req0_ready, req1_ready, dma_enable, rw, latch_sdram_addr_src, latch_sdram_addr_dst,
            latch_mem1_addr, latch_mem2_addr, busy, grant_id, xfer_done, err};
  endfunction

  // Beat responder: beat_done two cycles after each dma_enable, unless withheld.
  int pend = 0;
  bit hold_bd = 0, stray = 0;
  initial begin
    beat_done = 0;
    forever begin
      @(posedge clk_h); #1;
      beat_done = stray;
      if (!rst_n) pend = 0;
      else begin
        if (pend > 0) begin pend--; if (pend == 0) beat_done = 1; end
        if (dma_enable && !hold_bd) pend = 2;
      end
    end
  end

  // Descriptor-level model: beat k of a descriptor targets sdram base+k and mem base+k.
  bit m_idle = 1, m_rr = 1, m_issue = 0, m_done = 0, m_wait = 0, m_err = 0, m_gnt = 0, m_rw = 0;
  bit n_issue, n_done, er0, er1;
  int m_sd, m_mem, m_k, m_n, m_tcnt, sd, cyc = 0, cyc_en = 0, cyc_done = 0;
  int src_log[$], dst_log[$], mem_log[$], gnt_log[$];
  int done_cnt = 0, beat_cnt = 0;

  always @(negedge clk_h) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", all_outs(), 64'd0);
      m_idle = 1; m_rr = 1; m_issue = 0; m_done = 0; m_wait = 0; m_err = 0;
    end else begin
      er0 = 0; er1 = 0;
      if (m_idle) begin
        if (req0_valid && req1_valid) begin er0 = m_rr; er1 = !m_rr; end
        else begin er0 = req0_valid; er1 = req1_valid; end
      end
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      chk("dma_enable", dma_enable, m_issue);
      chk("xfer_done", xfer_done, m_done);
      chk("busy", busy, !m_idle);
      chk("err", err, m_err);
      if (!m_idle) begin
        sd = (m_sd + m_k) % 256;
        chk("rw", rw, m_rw);
        chk("grant_id", grant_id, m_gnt);
        chk("src", latch_sdram_addr_src, m_rw ? 0 : sd);
        chk("dst", latch_sdram_addr_dst, m_rw ? sd : 0);
        chk("mem1", latch_mem1_addr, (m_mem + m_k) % 64);
        chk("mem2", latch_mem2_addr, (m_mem + m_k) % 64);
      end
      if (dma_enable) begin
        src_log.push_back(latch_sdram_addr_src); dst_log.push_back(latch_sdram_addr_dst);
        mem_log.push_back(latch_mem1_addr); beat_cnt++; cyc_en = cyc;
      end
      if (xfer_done) begin done_cnt++; cyc_done = cyc; end
      if (req0_ready && req0_valid) gnt_log.push_back(0);
      if (req1_ready && req1_valid) gnt_log.push_back(1);

      n_issue = 0; n_done = 0;
      if (m_idle) begin
        if (er0 || er1) begin
          m_gnt = er1;
          m_rw  = er1 ? req1_rw : req0_rw;
          m_sd  = er1 ? req1_sdram_addr : req0_sdram_addr;
          m_mem = er1 ? req1_mem_addr : req0_mem_addr;
          m_n   = er1 ? req1_len : req0_len;
          if (m_n == 0) m_n = 16;
          m_k = 0; m_idle = 0; m_err = 0; n_issue = 1;
        end
      end else if (m_issue) begin
        m_wait = 1; m_tcnt = 0;
      end else if (m_wait) begin
        if (beat_done) begin
          m_wait = 0;
          if (m_k + 1 == m_n) n_done = 1;
          else begin m_k++; n_issue = 1; end
        end
`ifdef DMA_SCHED_TIMEOUT_EN
        else begin
          m_tcnt++;
          if (m_tcnt == TMO) begin m_wait = 0; m_err = 1; n_done = 1; end
        end
`endif
      end else if (m_done) begin
        m_idle = 1; m_rr = m_gnt;
      end
      m_issue = n_issue; m_done = n_done;
    end
  end

  task automatic clear_logs();
    src_log.delete(); dst_log.delete(); mem_log.delete(); gnt_log.delete();
    beat_cnt = 0; done_cnt = 0;
  endtask

  task automatic wait_grants(string nm, int n, int budget);
    int i = 0;
    while (gnt_log.size() < n && i < budget) begin @(posedge clk_h); i++; end
    chk({nm, "_grant_seen"}, gnt_log.size() >= n, 1);
    #1;
  endtask

  task automatic wait_done(string nm, int n, int budget);
    int i = 0;
    while (done_cnt < n && i < budget) begin @(posedge clk_h); i++; end
    chk({nm, "_done_seen"}, done_cnt >= n, 1);
    @(posedge clk_h); #1;
  endtask

  task automatic chk_q(string nm, int q[$], int e[$]);
    chk({nm, "_count"}, q.size(), e.size());
    for (int i = 0; i < e.size() && i < q.size(); i++) chk(nm, q[i], e[i]);
  endtask

  initial begin
    int e[$];
    repeat (3) @(posedge clk_h);
    #1 chk("reset_lit", all_outs(), 64'd0);
    rst_n = 1;

    // single req0 transfer with mem wrap
    clear_logs();
    @(posedge clk_h); #1;
    req0_rw = 0; req0_sdram_addr = 8'h10; req0_mem_addr = 6'h3E; req0_len = 3; req0_valid = 1;
    wait_grants("t1", 1, 10); req0_valid = 0;
    wait_done("t1", 1, 60);
    e = '{16, 17, 18}; chk_q("t1_src", src_log, e);
    e = '{62, 63, 0};  chk_q("t1_mem", mem_log, e);
    e = '{0, 0, 0};    chk_q("t1_dst", dst_log, e);
    chk("t1_done_cnt", done_cnt, 1);

    // req1 memory->SDRAM with sdram wrap
    clear_logs();
    req1_rw = 1; req1_sdram_addr = 8'hFF; req1_mem_addr = 6'h05; req1_len = 2; req1_valid = 1;
    wait_grants("t2", 1, 10); req1_valid = 0;
    wait_done("t2", 1, 60);
    e = '{255, 0}; chk_q("t2_dst", dst_log, e);
    e = '{0, 0};   chk_q("t2_src", src_log, e);
    e = '{5, 6};   chk_q("t2_mem", mem_log, e);

    // stray beat_done while idle is ignored
    @(negedge clk_h); stray = 1; @(negedge clk_h); stray = 0;
    repeat (3) @(posedge clk_h); #1;
    chk("stray_busy", busy, 0);

    // both requesters valid continuously, single beats
    clear_logs();
    req0_rw = 0; req0_sdram_addr = 8'h20; req0_mem_addr = 6'h01; req0_len = 1;
    req1_rw = 1; req1_sdram_addr = 8'h80; req1_mem_addr = 6'h02; req1_len = 1;
    req0_valid = 1; req1_valid = 1;
    wait_grants("t3", 4, 80); req0_valid = 0; req1_valid = 0;
    wait_done("t3", 4, 40);
    e = '{0, 1, 0, 1}; chk_q("t3_grants", gnt_log, e);

    // len 0 means 16 beats
    clear_logs();
    req0_rw = 0; req0_sdram_addr = 8'hF8; req0_mem_addr = 6'h38; req0_len = 0; req0_valid = 1;
    wait_grants("t4", 1, 10); req0_valid = 0;
    wait_done("t4", 1, 200);
    chk("t4_beats", beat_cnt, 16);
    chk("t4_last_src", src_log.size() == 16 ? src_log[15] : -1, 7);
    chk("t4_last_mem", mem_log.size() == 16 ? mem_log[15] : -1, 7);
    chk("t4_done_cnt", done_cnt, 1);

    // reset during WAIT of beat 2
    clear_logs();
    req0_rw = 0; req0_sdram_addr = 8'h40; req0_mem_addr = 6'h00; req0_len = 3; req0_valid = 1;
    wait_grants("t5", 1, 10); req0_valid = 0;
    for (int i = 0; i < 20 && beat_cnt < 2; i++) @(posedge clk_h);
    chk("t5_second_beat", beat_cnt, 2);
    @(posedge clk_h); #3;
    rst_n = 0;
    #1 chk("t5_async_reset", all_outs(), 64'd0);
    req0_sdram_addr = 8'h60; req1_sdram_addr = 8'h70; req0_len = 1; req1_len = 1;
    req0_valid = 1; req1_valid = 1;
    @(posedge clk_h); #1 chk("t5_ready_in_reset", {req0_ready, req1_ready}, 0);
    @(posedge clk_h); #1;
    chk("t5_no_done", done_cnt, 0);
    clear_logs();
    rst_n = 1;
    wait_grants("t5b", 1, 10); req0_valid = 0; req1_valid = 0;
    chk("t5_req0_first", gnt_log[0], 0);
    wait_done("t5b", 1, 40);
    e = '{96}; chk_q("t5_src", src_log, e);
    chk("t5_done_cnt", done_cnt, 1);

`ifdef DMA_SCHED_TIMEOUT_EN
    // timeout: beat_done withheld
    clear_logs();
    hold_bd = 1;
    req0_rw = 0; req0_sdram_addr = 8'h30; req0_mem_addr = 6'h00; req0_len = 3; req0_valid = 1;
    wait_grants("t6", 1, 10); req0_valid = 0;
    wait_done("t6", 1, 40);
    chk("t6_beats", beat_cnt, 1);
    chk("t6_wait_cycles", cyc_done - cyc_en, 5);
    chk("t6_err_sticky", err, 1);
    hold_bd = 0;
    clear_logs();
    req1_rw = 0; req1_sdram_addr = 8'h00; req1_len = 1; req1_valid = 1;
    wait_grants("t6b", 1, 10); req1_valid = 0;
    wait_done("t6b", 1, 40);
    chk("t6_err_cleared", err, 0);
`endif

    repeat (2) @(posedge clk_h);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_sched.md
DMA_SCHED -- requirements
Module: dma_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum WAIT-state cycles per beat (used only when DMA_SCHED_TIMEOUT_EN is defined); legal range 1..255.
REQ-002 SHALL use reset rst_n, asynchronous, active-low, and clock clk_h.
REQ-003 SHALL have port clk_h, input, 1, clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports reqN_valid (N=0,1), input, 1, descriptor valid.
REQ-006 SHALL have ports reqN_ready, output, 1, descriptor accepted this cycle.
REQ-007 SHALL have ports reqN_rw, input, 1, transfer direction: 0 = SDRAM->memory, 1 = memory->SDRAM.
REQ-008 SHALL have ports reqN_sdram_addr, input, 8, SDRAM start address.
REQ-009 SHALL have ports reqN_mem_addr, input, 6, buffer start address.
REQ-010 SHALL have ports reqN_len, input, 4, beat count; 0 means 16.
REQ-011 SHALL have port beat_done, input, 1, one-cycle pulse from the DMA when a beat completes.
REQ-012 SHALL have port dma_enable, output, 1, one-cycle beat start.
REQ-013 SHALL have port rw, output, 1, direction of the current transfer.
REQ-014 SHALL have ports latch_sdram_addr_src and latch_sdram_addr_dst, output, 8 each, beat SDRAM addresses.
REQ-015 SHALL have ports latch_mem1_addr and latch_mem2_addr, output, 6 each, beat buffer addresses.
REQ-016 SHALL have port busy, output, 1, transfer in progress.
REQ-017 SHALL have port grant_id, output, 1, requester currently owning the DMA.
REQ-018 SHALL have port xfer_done, output, 1, one-cycle end-of-descriptor pulse.
REQ-019 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-020 SHALL implement an FSM with states IDLE, ISSUE, WAIT, DONE.
REQ-021 In IDLE, SHALL assert ready combinationally to one valid requester only: the sole valid one; if both are valid, the one not granted last (round-robin pointer, reset value 1, so req0 wins first).
REQ-022 On a valid&ready edge, SHALL capture the descriptor and go to ISSUE; ready SHALL be 0 in all other states.
REQ-023 In ISSUE, SHALL assert dma_enable for exactly one cycle, then go to WAIT.
REQ-024 In WAIT, on beat_done: if the remaining count is 1, go to DONE; else increment the SDRAM address (mod 256) and the mem address (mod 64), decrement the remaining count, and go to ISSUE.
REQ-025 SHALL ignore beat_done outside WAIT.
REQ-026 In DONE, SHALL pulse xfer_done for one cycle, update the round-robin pointer to grant_id, and return to IDLE; the next grant is therefore at the earliest 1 cycle after DONE.
REQ-027 When rw=0, SHALL drive latch_sdram_addr_src = current SDRAM address and latch_sdram_addr_dst = 0; when rw=1, the reverse.
REQ-028 SHALL drive latch_mem1_addr = latch_mem2_addr = current mem address.
REQ-029 All address, rw and grant_id outputs SHALL be registered and stable from ISSUE until the exit from DONE.
REQ-030 SHALL assert busy in ISSUE, WAIT and DONE.
REQ-031 SHALL clear err when a new descriptor is accepted.

Reset
REQ-032 On rst_n low, SHALL go to IDLE at once, including mid-transfer with no xfer_done pulse.
REQ-033 Under reset, SHALL hold every output at 0 and the round-robin pointer at 1.

Configuration
REQ-034 With DMA_SCHED_TIMEOUT_EN defined, SHALL count cycles in WAIT (counter cleared on entry to WAIT).
REQ-035 With DMA_SCHED_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without beat_done, SHALL set err, abandon the remaining beats and go to DONE.
REQ-036 With DMA_SCHED_TIMEOUT_EN defined, beat_done arriving in the same cycle as the timeout SHALL take priority over the timeout.
REQ-037 Without DMA_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely, err SHALL be constant 0, and no counter SHALL exist.

Verification
REQ-038 Single request: req0 {rw=0, sdram=0x10, mem=0x3E, len=3}, beat_done 2 cycles after each dma_enable -> 3 dma_enable pulses; src = 0x10, 0x11, 0x12; mem = 0x3E, 0x3F, 0x00; dst = 0; one xfer_done.
REQ-039 Both requesters valid continuously with len=1 -> grants alternate req0, req1, req0, req1; each ready pulse lasts one cycle.
REQ-040 req1 {rw=1, sdram=0xFF, len=2} -> dst = 0xFF then 0x00; src = 0; rw=1 throughout.
REQ-041 len=0 -> exactly 16 beats, then xfer_done.
REQ-042 rst_n low during the WAIT of beat 2 -> all outputs 0 asynchronously, no xfer_done; after release, a new request is served from IDLE with req0 priority.
REQ-043 With DMA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=4, withhold beat_done -> err=1 and xfer_done pulse after 4 WAIT cycles; the next accepted descriptor clears err.
